// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver: hex font,
// segment bit positions and the scan step divider calculation.
package seg_scan_driver_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high {g,f,e,d,c,b,a} patterns for 0-F, with lowercase b and d.
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Clocks per PWM phase step; 0 flags an unusable clock/scan combination.
  function automatic int step_div(input int clk_hz, input int scan_hz);
    if (scan_hz <= 0 || clk_hz <= 0) return 0;
    return clk_hz / (scan_hz * 16);
  endfunction

endpackage

// File: rtl/seg_scan_driver_hex_to_seg7.sv
// Hex nibble to active-high segment pattern with blanking and decimal point.
module hex_to_seg7
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg[SEG_DP]      = dp;
  assign seg[SEG_G:SEG_A] = blank ? 7'h00 : HEX_FONT[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: BANKS displays of DPB digits each,
// PWM brightness, leading-zero blanking and a frame-aligned load handshake.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int CLK_HZ         = 100000000,
  parameter int SCAN_HZ        = 1000,
  parameter int DPB            = 4,
  parameter int BANKS          = 2,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4*DPB*BANKS-1:0]   data,
  input  logic [DPB*BANKS-1:0]     dp,
  input  logic                     data_valid,
  output logic                     data_ready,
  input  logic                     lz_blank,
  input  logic [3:0]               brightness,
  output logic [8*BANKS-1:0]       seg,
  output logic [DPB*BANKS-1:0]     an,
  output logic                     frame_start
);

  localparam int N        = DPB * BANKS;
  localparam int STEP_DIV = step_div(CLK_HZ, SCAN_HZ);
  localparam int CW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int IW       = $clog2(DPB);

  if (STEP_DIV < 1) begin : g_bad_step_div
    $error("seg_scan_driver: CLK_HZ/(SCAN_HZ*16) must be at least 1");
  end

  logic [CW-1:0]  step_cnt;
  logic [3:0]     phase;
  logic [IW-1:0]  idx;
  logic [4*N-1:0] pend_data, disp_data;
  logic [N-1:0]   pend_dp, disp_dp;
  logic           pend_lz, disp_lz, pend_full;
  logic [8*BANKS-1:0] seg_q, seg_next;
  logic [N-1:0]   an_q, an_next, blank;
  logic           frame_q;

  logic step_tc, slot_end, wrap, load, pwm_on;

  assign step_tc  = (step_cnt == CW'(STEP_DIV - 1));
  assign slot_end = step_tc && (phase == 4'hF);
  assign wrap     = slot_end && (idx == IW'(DPB - 1));
  assign load     = data_valid && !pend_full;
  assign pwm_on   = (phase < brightness);

  // NOTE: every register, including the pending and display copies, is
  // cleared by reset so a mid-frame reset discards any half-finished load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_cnt  <= '0;
      phase     <= '0;
      idx       <= '0;
      pend_data <= '0;
      pend_dp   <= '0;
      pend_lz   <= 1'b0;
      pend_full <= 1'b0;
      disp_data <= '0;
      disp_dp   <= '0;
      disp_lz   <= 1'b0;
      frame_q   <= 1'b0;
      seg_q     <= '0;
      an_q      <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every process
      // sees the pre-edge values regardless of evaluation order.
      step_cnt <= step_tc ? '0 : step_cnt + 1'b1;
      if (step_tc)  phase <= phase + 1'b1;
      if (slot_end) idx   <= wrap ? '0 : idx + 1'b1;
      frame_q <= wrap;
      seg_q   <= seg_next;
      an_q    <= an_next;
      // A load accepted on the wrap cycle itself only lands at the next wrap.
      if (wrap && pend_full) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
        disp_lz   <= pend_lz;
        pend_full <= 1'b0;
      end else if (load) begin
        pend_data <= data;
        pend_dp   <= dp;
        pend_lz   <= lz_blank;
        pend_full <= 1'b1;
      end
    end
  end

  // Leading-zero blanking, scanning from the most significant digit down.
  always_comb begin
    logic zero_above;
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    blank      = '0;
    zero_above = 1'b1;
    for (int k = N - 1; k >= 0; k--) begin
      // NOTE: blocking assignments here carry zero_above down the loop
      // within one evaluation.
      zero_above = zero_above && (disp_data[4*k +: 4] == 4'h0) && !disp_dp[k];
      blank[k]   = disp_lz && zero_above && (k != 0);
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    localparam int BASE = b * DPB;
    logic [3:0] nib;
    logic       blk, dpb;

    assign nib = disp_data[4*(BASE + int'(idx)) +: 4];
    assign blk = blank[BASE + int'(idx)];
    assign dpb = disp_dp[BASE + int'(idx)];

    hex_to_seg7 u_hex (
      .nibble (nib),
      .blank  (blk),
      .dp     (dpb),
      .seg    (seg_next[8*b +: 8])
    );

    assign an_next[BASE +: DPB] = pwm_on ? (DPB'(1) << idx) : '0;
  end

  assign data_ready  = !pend_full;
  assign frame_start = frame_q;
  assign seg = seg_q ^ {(8*BANKS){SEG_ACTIVE_LOW != 0}};
  assign an  = an_q  ^ {N{AN_ACTIVE_LOW != 0}};

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: 2 banks x 4 digits, active-low outputs,
// 2 clocks per PWM step, 32-clock digit slots, 128-clock frames.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  dp = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        lz_blank = 1'b0;
  logic [3:0]  brightness = 4'd15;
  logic [15:0] seg;
  logic [7:0]  an;
  logic        frame_start;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] seg_at [4];
  int          an_low [8];
  int          rdy_low;
  int          fs_cnt;
  int          fs_pos;

  seg_scan_driver #(
    .CLK_HZ(3200), .SCAN_HZ(100), .DPB(4), .BANKS(2),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data        (data),
    .dp          (dp),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .lz_blank    (lz_blank),
    .brightness  (brightness),
    .seg         (seg),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one 128-clock frame from a frame boundary, optionally pulsing a load
  // at clock load_at and an all-F load attempt at clock junk_at.
  task automatic run_frame(input int load_at, input int junk_at);
    logic [31:0] sd;
    logic [7:0]  sdp;
    rdy_low = 0;
    fs_cnt  = 0;
    fs_pos  = 0;
    for (int k = 0; k < 8; k++) an_low[k] = 0;
    for (int j = 1; j <= 128; j++) begin
      if (j == load_at) data_valid = 1'b1;
      if (j == junk_at) begin
        sd = data; sdp = dp;
        data = 32'hFFFF_FFFF; dp = 8'hFF; data_valid = 1'b1;
      end
      tick;
      if (j == junk_at) begin
        data = sd; dp = sdp;
      end
      data_valid = 1'b0;
      if ((j - 1) % 32 == 0) seg_at[(j - 1) / 32] = seg;
      for (int k = 0; k < 8; k++) if (!an[k]) an_low[k]++;
      if (!data_ready) rdy_low++;
      if (frame_start) begin
        fs_cnt++;
        fs_pos = j;
      end
    end
  endtask

  task automatic test_reset;
    int found;
    rst_n = 1'b0;
    brightness = 4'd15;
    repeat (3) tick;
    n_cmp++; if (seg !== 16'hFFFF) begin n_err++; $display("FAIL reset_seg: got %h expected ffff", seg); end
    n_cmp++; if (an !== 8'hFF) begin n_err++; $display("FAIL reset_an: got %h expected ff", an); end
    n_cmp++; if (data_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", data_ready); end
    n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
    rst_n = 1'b1;
    found = 0;
    for (int j = 1; j <= 300 && found == 0; j++) begin
      tick;
      if (j == 1) begin
        n_cmp++; if (an !== 8'hEE) begin n_err++; $display("FAIL scan_idx0: got %h expected ee", an); end
        n_cmp++; if (seg !== ~16'h3F3F) begin n_err++; $display("FAIL reset_digits: got %h expected %h", seg, ~16'h3F3F); end
      end
      if (j == 31) begin
        n_cmp++; if (an !== 8'hFF) begin n_err++; $display("FAIL pwm_phase15_off: got %h expected ff", an); end
      end
      if (j == 33) begin
        n_cmp++; if (an !== 8'hDD) begin n_err++; $display("FAIL scan_idx1: got %h expected dd", an); end
      end
      if (j == 65) begin
        n_cmp++; if (an !== 8'hBB) begin n_err++; $display("FAIL scan_idx2: got %h expected bb", an); end
      end
      if (j == 97) begin
        n_cmp++; if (an !== 8'h77) begin n_err++; $display("FAIL scan_idx3: got %h expected 77", an); end
      end
      if (frame_start) found = j;
    end
    n_cmp++; if (found !== 128) begin n_err++; $display("FAIL first_frame_start: got %0d expected 128", found); end
  endtask

  task automatic test_load;
    logic [15:0] exp_seg [4];
    data = 32'h1234ABCD; dp = 8'h00; lz_blank = 1'b0; brightness = 4'd15;
    run_frame(1, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (seg_at[i] !== ~16'h3F3F) begin n_err++; $display("FAIL load_old_slot%0d: got %h expected %h", i, seg_at[i], ~16'h3F3F); end
    end
    n_cmp++; if (rdy_low !== 127) begin n_err++; $display("FAIL load_ready_low: got %0d expected 127", rdy_low); end
    n_cmp++; if (data_ready !== 1'b1) begin n_err++; $display("FAIL load_ready_back: got %b expected 1", data_ready); end
    run_frame(0, 0);
    exp_seg = '{~16'h665E, ~16'h4F39, ~16'h5B7C, ~16'h0677};
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (seg_at[i] !== exp_seg[i]) begin n_err++; $display("FAIL load_new_slot%0d: got %h expected %h", i, seg_at[i], exp_seg[i]); end
    end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (an_low[k] !== 30) begin n_err++; $display("FAIL bright15_an%0d: got %0d expected 30", k, an_low[k]); end
    end
    n_cmp++; if (fs_cnt !== 1 || fs_pos !== 128) begin n_err++; $display("FAIL frame_start_pos: got %0d pulses at %0d expected 1 at 128", fs_cnt, fs_pos); end
  endtask

  task automatic test_mid_load;
    logic [15:0] exp_seg [4];
    data = 32'h89EF0567;
    run_frame(50, 70);
    n_cmp++; if (seg_at[2] !== ~16'h5B7C) begin n_err++; $display("FAIL mid_old_slot2: got %h expected %h", seg_at[2], ~16'h5B7C); end
    n_cmp++; if (seg_at[3] !== ~16'h0677) begin n_err++; $display("FAIL mid_old_slot3: got %h expected %h", seg_at[3], ~16'h0677); end
    n_cmp++; if (rdy_low !== 78) begin n_err++; $display("FAIL mid_ready_low: got %0d expected 78", rdy_low); end
    run_frame(0, 0);
    exp_seg = '{~16'h7107, ~16'h797D, ~16'h6F6D, ~16'h7F3F};
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (seg_at[i] !== exp_seg[i]) begin n_err++; $display("FAIL mid_new_slot%0d: got %h expected %h", i, seg_at[i], exp_seg[i]); end
    end
  endtask

  task automatic test_lz_blank;
    logic [15:0] exp_seg [4];
    data = 32'h00000050; dp = 8'h00; lz_blank = 1'b1;
    run_frame(1, 0);
    run_frame(0, 0);
    exp_seg = '{~16'h003F, ~16'h006D, 16'hFFFF, 16'hFFFF};
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (seg_at[i] !== exp_seg[i]) begin n_err++; $display("FAIL lz_slot%0d: got %h expected %h", i, seg_at[i], exp_seg[i]); end
    end
    dp = 8'h10;
    run_frame(1, 0);
    run_frame(0, 0);
    exp_seg = '{~16'hBF3F, ~16'h006D, ~16'h003F, ~16'h003F};
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (seg_at[i] !== exp_seg[i]) begin n_err++; $display("FAIL lz_dp_slot%0d: got %h expected %h", i, seg_at[i], exp_seg[i]); end
    end
    lz_blank = 1'b0; dp = 8'h00;
  endtask

  task automatic test_brightness;
    brightness = 4'd0;
    run_frame(0, 0);
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (an_low[k] !== 0) begin n_err++; $display("FAIL bright0_an%0d: got %0d expected 0", k, an_low[k]); end
    end
    brightness = 4'd8;
    run_frame(0, 0);
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (an_low[k] !== 16) begin n_err++; $display("FAIL bright8_an%0d: got %0d expected 16", k, an_low[k]); end
    end
    brightness = 4'd15;
  endtask

  task automatic test_reset_mid;
    data = 32'h77777777; dp = 8'h00; lz_blank = 1'b0;
    data_valid = 1'b1;
    tick;
    data_valid = 1'b0;
    repeat (40) tick;
    n_cmp++; if (data_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_pending: got %b expected 0", data_ready); end
    rst_n = 1'b0;
    tick;
    n_cmp++; if (seg !== 16'hFFFF) begin n_err++; $display("FAIL rstmid_seg: got %h expected ffff", seg); end
    n_cmp++; if (an !== 8'hFF) begin n_err++; $display("FAIL rstmid_an: got %h expected ff", an); end
    n_cmp++; if (data_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b expected 1", data_ready); end
    rst_n = 1'b1;
    run_frame(0, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (seg_at[i] !== ~16'h3F3F) begin n_err++; $display("FAIL rstmid_slot%0d: got %h expected %h", i, seg_at[i], ~16'h3F3F); end
    end
    n_cmp++; if (rdy_low !== 0) begin n_err++; $display("FAIL rstmid_ready_low: got %0d expected 0", rdy_low); end
    n_cmp++; if (fs_pos !== 128) begin n_err++; $display("FAIL rstmid_frame_start: got %0d expected 128", fs_pos); end
  endtask

  initial begin
    test_reset;
    test_load;
    test_mid_load;
    test_lz_blank;
    test_brightness;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
